// File: rtl/register_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// register_sequencer_pkg
// Shared encodings for the ForthCPU register sequencer:
//   - REG_SEQX_*     register sequence selector
//   - BYTEX_*        word / byte access width
//   - REG_BYTE_ENX_* port A byte-lane strobes
//   - PHASE_*        four-phase instruction timing
// Optional feature macro (used by the top level): REG_SEQ_BYTE_LANE_EN
// -----------------------------------------------------------------------------
package register_sequencer_pkg;

    localparam int INSTR_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        REG_SEQX_NONE    = 2'b00,
        REG_SEQX_RDA_RDB = 2'b01,
        REG_SEQX_UPA_RDB = 2'b10,
        REG_SEQX_WRA_UPB = 2'b11
    } reg_seqx_t;

    typedef enum logic {
        BYTEX_WORD = 1'b0,
        BYTEX_BYTE = 1'b1
    } bytex_t;

    typedef enum logic [1:0] {
        REG_BYTE_ENX_NONE = 2'b00,
        REG_BYTE_ENX_LOW  = 2'b01,
        REG_BYTE_ENX_HIGH = 2'b10,
        REG_BYTE_ENX_BOTH = 2'b11
    } reg_byte_enx_t;

    typedef enum logic [1:0] {
        PHASE_FETCH   = 2'b00,
        PHASE_DECODE  = 2'b01,
        PHASE_EXECUTE = 2'b10,
        PHASE_COMMIT  = 2'b11
    } phase_t;

    // The phase sequence never stalls, so the successor is a plain wrap-around.
    function automatic phase_t next_phase(input phase_t cur);
        return phase_t'(cur + 2'd1);
    endfunction

endpackage

// File: rtl/register_sequencer_instruction_phase_decoder.sv
// -----------------------------------------------------------------------------
// instruction_phase_decoder
// Free-running four-phase counter with one-hot phase strobes and the
// instruction latch.
//
// state   | meaning
// --------+-------------------------------------------------------------
// FETCH   | memory read data on DIN; latched at the end if PC_ENX=1
// DECODE  | instruction word stable for the decoder
// EXECUTE | register ports read
// COMMIT  | register ports written back
//
// Ports
//   CLK, RESET      clock, synchronous active-high reset
//   DIN             instruction source (memory read data)
//   PC_ENX          load enable for INSTRUCTION at the end of FETCH
//   FETCH..COMMIT   one-hot phase strobes, all 0 while RESET=1
//   INSTRUCTION     latched instruction word
// -----------------------------------------------------------------------------
module instruction_phase_decoder
    import register_sequencer_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEFAULT
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [INSTR_W-1:0] DIN,
    input  logic               PC_ENX,
    output logic               FETCH,
    output logic               DECODE,
    output logic               EXECUTE,
    output logic               COMMIT,
    output logic [INSTR_W-1:0] INSTRUCTION
);

    phase_t phase;
    phase_t phase_nxt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase <= PHASE_FETCH;
        end else begin
            phase <= phase_nxt;
        end
    end

    always_comb begin
        phase_nxt = next_phase(phase);
    end

    // Phase strobes are gated by RESET directly so that a reset arriving
    // mid-instruction silences them in the same cycle.
    always_comb begin
        FETCH   = 1'b0;
        DECODE  = 1'b0;
        EXECUTE = 1'b0;
        COMMIT  = 1'b0;
        if (!RESET) begin
            case (phase)
                PHASE_FETCH:   FETCH   = 1'b1;
                PHASE_DECODE:  DECODE  = 1'b1;
                PHASE_EXECUTE: EXECUTE = 1'b1;
                PHASE_COMMIT:  COMMIT  = 1'b1;
                default:       FETCH   = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            INSTRUCTION <= '0;
        end else if (phase == PHASE_FETCH && PC_ENX) begin
            INSTRUCTION <= DIN;
        end
    end

endmodule

// File: rtl/register_sequencer.sv
// -----------------------------------------------------------------------------
// register_sequencer
// Four-phase instruction timing plus register-file port control for the
// ForthCPU core. Port A/B enables, write enables and port A byte-lane strobes
// are decoded combinationally from the current phase and REG_SEQX/BYTEX/A0.
//
// Optional feature macro: REG_SEQ_BYTE_LANE_EN
//   defined     -> byte accesses on UPA_RDB/WRA_UPB select one lane by A0
//   not defined -> BYTEX/A0 ignored, port A always uses both lanes
//
// Ports
//   CLK, RESET               clock, synchronous active-high reset
//   DIN, PC_ENX              instruction source and its load enable
//   REG_SEQX, BYTEX, A0      register sequence, access width, byte address LSB
//   FETCH..COMMIT            one-hot phase strobes
//   INSTRUCTION              latched instruction word
//   REGA_BYTE_EN             port A lane strobes
//   REGA_EN/REGA_WEN         port A enable / write enable
//   REGB_EN/REGB_WEN         port B enable / write enable (always word-wide)
// -----------------------------------------------------------------------------
module register_sequencer
    import register_sequencer_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEFAULT
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [INSTR_W-1:0] DIN,
    input  logic               PC_ENX,
    input  logic [1:0]         REG_SEQX,
    input  logic               BYTEX,
    input  logic               A0,
    output logic               FETCH,
    output logic               DECODE,
    output logic               EXECUTE,
    output logic               COMMIT,
    output logic [INSTR_W-1:0] INSTRUCTION,
    output logic [1:0]         REGA_BYTE_EN,
    output logic               REGA_EN,
    output logic               REGA_WEN,
    output logic               REGB_EN,
    output logic               REGB_WEN
);

    reg_seqx_t seq;

    assign seq = reg_seqx_t'(REG_SEQX);

    instruction_phase_decoder #(
        .INSTR_W (INSTR_W)
    ) u_phase (
        .CLK         (CLK),
        .RESET       (RESET),
        .DIN         (DIN),
        .PC_ENX      (PC_ENX),
        .FETCH       (FETCH),
        .DECODE      (DECODE),
        .EXECUTE     (EXECUTE),
        .COMMIT      (COMMIT),
        .INSTRUCTION (INSTRUCTION)
    );

`ifndef REG_SEQ_BYTE_LANE_EN
    logic unused_lane_inputs;
    assign unused_lane_inputs = BYTEX ^ A0;
`endif

    always_comb begin
        REGA_BYTE_EN = REG_BYTE_ENX_NONE;
        REGA_EN      = 1'b0;
        REGA_WEN     = 1'b0;
        REGB_EN      = 1'b0;
        REGB_WEN     = 1'b0;
        if (!RESET && (EXECUTE || COMMIT) && seq != REG_SEQX_NONE) begin
            REGA_EN      = 1'b1;
            REGB_EN      = 1'b1;
            REGA_BYTE_EN = REG_BYTE_ENX_BOTH;
`ifdef REG_SEQ_BYTE_LANE_EN
            // Read-only sequences always fetch the full word from port A.
            if (seq != REG_SEQX_RDA_RDB && bytex_t'(BYTEX) == BYTEX_BYTE) begin
                REGA_BYTE_EN = A0 ? REG_BYTE_ENX_HIGH : REG_BYTE_ENX_LOW;
            end
`endif
            if (COMMIT) begin
                REGA_WEN = (seq == REG_SEQX_UPA_RDB) || (seq == REG_SEQX_WRA_UPB);
                REGB_WEN = (seq == REG_SEQX_WRA_UPB);
            end
        end
    end

endmodule

// File: tb/tb_register_sequencer.sv
// -----------------------------------------------------------------------------
// tb_register_sequencer
// Self-checking bench for register_sequencer. Each driven cycle pushes the
// expected output vector onto a scoreboard; the scenario tasks pop and compare
// on the falling edge.
// Output vector: {FETCH,DECODE,EXECUTE,COMMIT, INSTRUCTION, BYTE_EN,
//                 REGA_EN, REGA_WEN, REGB_EN, REGB_WEN}
// -----------------------------------------------------------------------------
module tb_register_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] DIN = 16'h0000;
    logic        PC_ENX = 1'b0;
    logic [1:0]  REG_SEQX = 2'b00;
    logic        BYTEX = 1'b0;
    logic        A0 = 1'b0;
    logic        FETCH, DECODE, EXECUTE, COMMIT;
    logic [15:0] INSTRUCTION;
    logic [1:0]  REGA_BYTE_EN;
    logic        REGA_EN, REGA_WEN, REGB_EN, REGB_WEN;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [1:0]  m_ph = 2'd0;
    logic [15:0] m_ins = 16'h0000;
    logic [25:0] sb[$];
    logic [25:0] exp_v;
    logic [25:0] obs_v;

    always #5 CLK = ~CLK;

    register_sequencer #(.INSTR_W(16)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .DIN          (DIN),
        .PC_ENX       (PC_ENX),
        .REG_SEQX     (REG_SEQX),
        .BYTEX        (BYTEX),
        .A0           (A0),
        .FETCH        (FETCH),
        .DECODE       (DECODE),
        .EXECUTE      (EXECUTE),
        .COMMIT       (COMMIT),
        .INSTRUCTION  (INSTRUCTION),
        .REGA_BYTE_EN (REGA_BYTE_EN),
        .REGA_EN      (REGA_EN),
        .REGA_WEN     (REGA_WEN),
        .REGB_EN      (REGB_EN),
        .REGB_WEN     (REGB_WEN)
    );

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [25:0] exp_out(input logic [1:0] ph, input logic [15:0] ins,
                                            input logic rst, input logic [1:0] seq,
                                            input logic bx, input logic a);
        logic [3:0] phs;
        logic [1:0] be;
        logic       ae, aw, bee, bw;
        logic       unused_lanes;
        phs = 4'b0000; be = 2'b00; ae = 1'b0; aw = 1'b0; bee = 1'b0; bw = 1'b0;
        unused_lanes = bx ^ a;
        if (!rst) begin
            phs = 4'b1000 >> ph;
            if ((ph == 2'd2 || ph == 2'd3) && seq != 2'b00) begin
                ae = 1'b1;
                bee = 1'b1;
                be = 2'b11;
`ifdef REG_SEQ_BYTE_LANE_EN
                if (seq != 2'b01 && bx) be = a ? 2'b10 : 2'b01;
`endif
                if (ph == 2'd3) begin
                    aw = (seq != 2'b01);
                    bw = (seq == 2'b11);
                end
            end
        end
        return {phs, ins, be, ae, aw, bee, bw};
    endfunction

    // Advance the reference model across the edge using the inputs that were
    // stable at that edge, then apply the next cycle's inputs.
    task automatic drive(input logic rst, input logic [1:0] seq, input logic bx,
                         input logic a, input logic [15:0] din, input logic pcen);
        @(posedge CLK);
        if (RESET) begin
            m_ph = 2'd0;
            m_ins = 16'h0000;
        end else begin
            if (m_ph == 2'd0 && PC_ENX) m_ins = DIN;
            m_ph = m_ph + 2'd1;
        end
        #1;
        RESET = rst; REG_SEQX = seq; BYTEX = bx; A0 = a; DIN = din; PC_ENX = pcen;
        sb.push_back(exp_out(m_ph, m_ins, rst, seq, bx, a));
    endtask

    task automatic test_reset();
        for (int i = 0; i < 11; i++) begin
            drive(i < 3, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0);
            @(negedge CLK);
            exp_v = sb.pop_front();
            obs_v = {FETCH, DECODE, EXECUTE, COMMIT, INSTRUCTION, REGA_BYTE_EN,
                     REGA_EN, REGA_WEN, REGB_EN, REGB_WEN};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL reset cyc=%0d observed=%h expected=%h", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_rda_rdb();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b0);
            @(negedge CLK);
            exp_v = sb.pop_front();
            obs_v = {FETCH, DECODE, EXECUTE, COMMIT, INSTRUCTION, REGA_BYTE_EN,
                     REGA_EN, REGA_WEN, REGB_EN, REGB_WEN};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL rda_rdb cyc=%0d observed=%h expected=%h", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_upa_rdb();
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 2'b10, i >= 4, i >= 8, 16'h0000, 1'b0);
            @(negedge CLK);
            exp_v = sb.pop_front();
            obs_v = {FETCH, DECODE, EXECUTE, COMMIT, INSTRUCTION, REGA_BYTE_EN,
                     REGA_EN, REGA_WEN, REGB_EN, REGB_WEN};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL upa_rdb cyc=%0d observed=%h expected=%h", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_wra_upb();
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 2'b11, i >= 4, i >= 4 && i < 8 ? 1'b1 : 1'b0, 16'h0000, 1'b0);
            @(negedge CLK);
            exp_v = sb.pop_front();
            obs_v = {FETCH, DECODE, EXECUTE, COMMIT, INSTRUCTION, REGA_BYTE_EN,
                     REGA_EN, REGA_WEN, REGB_EN, REGB_WEN};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL wra_upb cyc=%0d observed=%h expected=%h", cyc, obs_v, exp_v);
            end
        end
    endtask

    // Loads only happen at the end of FETCH: PC_ENX is held high with other
    // data outside FETCH, and low during the second FETCH.
    task automatic test_instr_latch();
        for (int i = 0; i < 12; i++) begin
            if (i == 0)
                drive(1'b0, 2'b10, 1'b0, 1'b0, 16'hA55A, 1'b1);
            else if (i == 4)
                drive(1'b0, 2'b10, 1'b0, 1'b0, 16'h1234, 1'b0);
            else if (i == 8)
                drive(1'b0, 2'b10, 1'b0, 1'b0, 16'h0F0F, 1'b1);
            else
                drive(1'b0, 2'b10, 1'b0, 1'b0, 16'hFFFF, 1'b1);
            @(negedge CLK);
            exp_v = sb.pop_front();
            obs_v = {FETCH, DECODE, EXECUTE, COMMIT, INSTRUCTION, REGA_BYTE_EN,
                     REGA_EN, REGA_WEN, REGB_EN, REGB_WEN};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL instr_latch cyc=%0d observed=%h expected=%h", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            drive(i == 2 || i == 3, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0);
            @(negedge CLK);
            exp_v = sb.pop_front();
            obs_v = {FETCH, DECODE, EXECUTE, COMMIT, INSTRUCTION, REGA_BYTE_EN,
                     REGA_EN, REGA_WEN, REGB_EN, REGB_WEN};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL reset_mid cyc=%0d observed=%h expected=%h", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 64; i++) begin
            drive($urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom), 1'($urandom_range(0, 1)));
            @(negedge CLK);
            exp_v = sb.pop_front();
            obs_v = {FETCH, DECODE, EXECUTE, COMMIT, INSTRUCTION, REGA_BYTE_EN,
                     REGA_EN, REGA_WEN, REGB_EN, REGB_WEN};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL back_to_back cyc=%0d observed=%h expected=%h", cyc, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rda_rdb();
        test_upa_rdb();
        test_wra_upb();
        test_instr_latch();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
